axil_rf_bank: RTL and testbench
===============================

# axil_rf_bank

Parametrised AXI-Lite slave register bank that terminates the PS AXI-Lite port directly, replacing the fixed adapter-plus-node register file. It adds a configurable register count, byte write strobes, per-register read-only (hardware-fed) slots, and SLVERR responses for illegal accesses. Fabric logic sees every register on a flat vector plus a one-cycle write-commit pulse per register.

## Interface
- DATA_WIDTH, 32, register and bus data width; multiple of 8.
- ADDR_WIDTH, 8, byte address width; must satisfy 2^ADDR_WIDTH ≥ NUM_REGS·DATA_WIDTH/8.
- NUM_REGS, 16, number of registers; index i is at byte address i·(DATA_WIDTH/8).
- RO_MASK, '0, NUM_REGS bits; bit i set means register i is read-only and reads return reg_i slice i.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- waddr  in  ADDR_WIDTH  write address; wavalid in 1; waready out 1.
- wdata  in  DATA_WIDTH  write data; wstrb in DATA_WIDTH/8 byte enables; wvalid in 1; wready out 1.
- wresp  out  2  write response (00 OKAY, 10 SLVERR); bvalid out 1; bready in 1.
- raddr  in  ADDR_WIDTH  read address; arvalid in 1; arready out 1.
- rdata  out  DATA_WIDTH  read data; rresp out 2; rvalid out 1; rready in 1.
- reg_o  out  NUM_REGS·DATA_WIDTH  register contents, slice i = register i (RO slots drive 0).
- reg_i  in  NUM_REGS·DATA_WIDTH  hardware values for RO slots; ignored for RW slots.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on committed write to register i.

## Operation
- Address decode: index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored. Index ≥ NUM_REGS → SLVERR; write to RO slot → SLVERR. SLVERR writes change nothing and pulse nothing; SLVERR reads return rdata = 0.
- Write FSM: WR_IDLE (waready=wready=1) → AW only: WR_WAIT_W (waready=0, wready=1); W only: WR_WAIT_A (waready=1, wready=0); both same cycle or completing the pair: WR_RESP. WR_RESP: waready=wready=0, bvalid=1, wresp held; on bvalid&bready → WR_IDLE.
- Commit: byte k of register updated iff wstrb[k]; wstrb = 0 is OKAY with no data change but still pulses.
- Read FSM: RD_IDLE (arready=1) → on arvalid&arready capture data/resp → RD_DATA (arready=0, rvalid=1, rdata/rresp stable) → on rready → RD_IDLE. Read and write channels fully independent.
- RO slot reads sample reg_i at the AR handshake edge.

## Timing
- Reset: all registers 0; waready, wready, arready, bvalid, rvalid, wresp, rresp, rdata, wr_pulse_o all 0. Readies held 0 by a registered out-of-reset flag; they rise the first cycle after rst deasserts.
- Write: last of AW/W handshake at edge t → at edge t+1: reg_o updated, bvalid=1, wr_pulse_o[i]=1 (that cycle only). Max throughput one write per 2 cycles with bready held high.
- Read: AR handshake at edge t → rvalid=1 from edge t+1. Max throughput one read per 2 cycles.
- Same-edge AR handshake and write commit to the same register: read returns the pre-write value.
- bvalid/rvalid held with stable payload until accepted; no new AW/W/AR accepted meanwhile.
- rst asserted mid-transaction: FSMs to idle immediately, valids drop asynchronously, captured-but-uncommitted write discarded.

## Structure
- Package axil_rf_pkg: resp_t (RESP_OKAY 2'b00, RESP_SLVERR 2'b10), wr_state_t (WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP), rd_state_t (RD_IDLE, RD_DATA).
- Sub-module axil_rf_decode: combinational address → {index, in_range, is_ro}; instantiated twice (write and read paths).

## Test plan
- Reset then write 0xDEADBEEF to 0x04, wstrb=0xF, AW and W in same cycle → bvalid next cycle, wresp=00, reg_o slice 1 = 0xDEADBEEF, wr_pulse_o=0x0002 for one cycle.
- W 3 cycles before AW, wstrb=0x3, data 0x0000AAAA to reg 1 holding 0xDEADBEEF → reg 1 = 0xDEADAAAA, bvalid one cycle after AW handshake.
- Write 0x40 (index 16, NUM_REGS=16) and write to RO reg 2 (RO_MASK bit 2) → wresp=10, no reg_o change, no pulse; read 0x40 → rresp=10, rdata=0.
- RO reg 2 with reg_i slice 2 = 0x12345678 → read 0x08 gives rdata 0x12345678, rresp=00.
- Hold bready=0 / rready=0 for 5 cycles → bvalid/rvalid and payloads stable, waready/wready/arready stay 0.
- Assert rst after AW accepted, before W → readies/valids 0, all registers 0, no pulse; fresh write after reset completes normally.

Source files
------------

// File: rtl/axil_rf_pkg.sv
// Shared types for the AXI-Lite register bank: bus response codes and the
// write/read channel state encodings.
package axil_rf_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_A,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Number of byte-offset address bits below the register index.
  function automatic int offsetBits(int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/axil_rf_if.sv
// AXI-Lite style bus between the PS master and the register bank slave.
interface axil_rf_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   waddr;
  logic                    wavalid;
  logic                    waready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              wresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output waddr, wavalid, wdata, wstrb, wvalid, bready, raddr, arvalid, rready,
    input  waready, wready, wresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  waddr, wavalid, wdata, wstrb, wvalid, bready, raddr, arvalid, rready,
    output waready, wready, wresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_rf_decode.sv
// Combinational byte-address decode into register index, range and
// read-only flags; shared by the write and read paths.
module axil_rf_decode
  import axil_rf_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  localparam int                 IDX_W      = ADDR_WIDTH - offsetBits(DATA_WIDTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  in_range_o,
  output logic                  is_ro_o
);

  logic unusedOffsetBits;

  // Byte-offset bits carry no meaning for a register-granular bank.
  assign unusedOffsetBits = ^addr_i;
  assign idx_o            = addr_i[ADDR_WIDTH-1 -: IDX_W];

  always_comb begin
    in_range_o = 1'b0;
    is_ro_o    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_o == IDX_W'(i)) begin
        in_range_o = 1'b1;
        is_ro_o    = RO_MASK[i];
      end
    end
  end

endmodule

// File: rtl/axil_rf_bank.sv
// AXI-Lite slave register bank with byte strobes, hardware-fed read-only
// slots, SLVERR on illegal accesses and per-register write-commit pulses.
module axil_rf_bank
  import axil_rf_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axil_rf_if.slave                       bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W  = ADDR_WIDTH - offsetBits(DATA_WIDTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t               wrState_q, wrState_d;
  rd_state_t               rdState_q, rdState_d;
  logic                    alive_q;
  logic [ADDR_WIDTH-1:0]   awAddr_q;
  logic [DATA_WIDTH-1:0]   wData_q;
  logic [STRB_W-1:0]       wStrb_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     wrPulse_q, wrPulse_d;
  resp_t                   wResp_q, wResp_d, rResp_q, rResp_d;
  logic [DATA_WIDTH-1:0]   rData_q, rData_d;

  logic                    awReady, wReady, awHs, wHs, commit;
  logic                    arReady, arHs;
  logic [ADDR_WIDTH-1:0]   effAddr;
  logic [DATA_WIDTH-1:0]   effData;
  logic [STRB_W-1:0]       effStrb;
  logic [IDX_W-1:0]        wrIdx, rdIdx;
  logic                    wrInRange, wrIsRo, rdInRange, rdIsRo, wrOk, rdOk;
  logic [DATA_WIDTH-1:0]   rdVal;
  logic                    unusedRegIn;

  assign unusedRegIn = ^reg_i;

  // Completing half of a split write comes from the bus, the earlier half from its capture register.
  assign effAddr = (wrState_q == WR_WAIT_W) ? awAddr_q : bus.waddr;
  assign effData = (wrState_q == WR_WAIT_A) ? wData_q  : bus.wdata;
  assign effStrb = (wrState_q == WR_WAIT_A) ? wStrb_q  : bus.wstrb;

  axil_rf_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                   .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)) uWrDecode (
    .addr_i(effAddr), .idx_o(wrIdx), .in_range_o(wrInRange), .is_ro_o(wrIsRo)
  );

  axil_rf_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                   .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)) uRdDecode (
    .addr_i(bus.raddr), .idx_o(rdIdx), .in_range_o(rdInRange), .is_ro_o(rdIsRo)
  );

  assign wrOk = wrInRange && !wrIsRo;
  assign rdOk = rdInRange;

  always_comb begin
    wrState_d = wrState_q;
    awReady   = 1'b0;
    wReady    = 1'b0;
    commit    = 1'b0;
    case (wrState_q)
      WR_IDLE:   begin awReady = alive_q; wReady = alive_q; end
      WR_WAIT_W: wReady  = 1'b1;
      WR_WAIT_A: awReady = 1'b1;
      default:   ;
    endcase
    awHs = bus.wavalid && awReady;
    wHs  = bus.wvalid && wReady;
    case (wrState_q)
      WR_IDLE: begin
        if (awHs && wHs) begin
          wrState_d = WR_RESP;
          commit    = 1'b1;
        end else if (awHs) begin
          wrState_d = WR_WAIT_W;
        end else if (wHs) begin
          wrState_d = WR_WAIT_A;
        end
      end
      WR_WAIT_W: if (wHs)  begin wrState_d = WR_RESP; commit = 1'b1; end
      WR_WAIT_A: if (awHs) begin wrState_d = WR_RESP; commit = 1'b1; end
      WR_RESP:   if (bus.bready) wrState_d = WR_IDLE;
      default:   wrState_d = WR_IDLE;
    endcase
  end

  always_comb begin
    regs_d    = regs_q;
    wrPulse_d = '0;
    wResp_d   = wResp_q;
    if (commit) begin
      wResp_d = wrOk ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrOk && wrIdx == IDX_W'(i)) begin
          wrPulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (effStrb[k]) regs_d[i][8*k +: 8] = effData[8*k +: 8];
          end
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge write commit is not yet visible.
  always_comb begin
    rdVal = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rdIdx == IDX_W'(i)) rdVal = RO_MASK[i] ? reg_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
    end
    rdState_d = rdState_q;
    rData_d   = rData_q;
    rResp_d   = rResp_q;
    arReady   = alive_q && (rdState_q == RD_IDLE);
    arHs      = bus.arvalid && arReady;
    case (rdState_q)
      RD_IDLE: begin
        if (arHs) begin
          rdState_d = RD_DATA;
          rData_d   = rdOk ? rdVal : '0;
          rResp_d   = rdOk ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RD_DATA: if (bus.rready) rdState_d = RD_IDLE;
      default: rdState_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrState_q <= WR_IDLE;
      rdState_q <= RD_IDLE;
      alive_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      regs_q    <= '{default: '0};
      wrPulse_q <= '0;
      wResp_q   <= RESP_OKAY;
      rResp_q   <= RESP_OKAY;
      rData_q   <= '0;
    end else begin
      wrState_q <= wrState_d;
      rdState_q <= rdState_d;
      alive_q   <= 1'b1;
      regs_q    <= regs_d;
      wrPulse_q <= wrPulse_d;
      wResp_q   <= wResp_d;
      rResp_q   <= rResp_d;
      rData_q   <= rData_d;
      if (awHs) awAddr_q <= bus.waddr;
      if (wHs) begin
        wData_q <= bus.wdata;
        wStrb_q <= bus.wstrb;
      end
    end
  end

  always_comb begin
    reg_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  assign wr_pulse_o  = wrPulse_q;
  assign bus.waready = awReady;
  assign bus.wready  = wReady;
  assign bus.bvalid  = (wrState_q == WR_RESP);
  assign bus.wresp   = wResp_q;
  assign bus.arready = arReady;
  assign bus.rvalid  = (rdState_q == RD_DATA);
  assign bus.rdata   = rData_q;
  assign bus.rresp   = rResp_q;

endmodule

// File: tb/tb_axil_rf_bank.sv
// Self-checking bench for axil_rf_bank: vector table plus hand-written
// sequences for split writes, backpressure, same-edge hazards and reset.
module tb_axil_rf_bank;
  import axil_rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*DW-1:0] regO, regI;
  logic [NR-1:0]    wrPulse;

  always #5 clk = ~clk;

  axil_rf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_rf_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reg_o(regO), .reg_i(regI), .wr_pulse_o(wrPulse)
  );

  typedef struct { logic [1:0] resp; logic [NR-1:0] pulse; } wr_exp_t;
  typedef struct { logic [1:0] resp; logic [DW-1:0] data; } rd_exp_t;
  typedef struct {
    bit isRead; logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] strb;
    logic [1:0] expResp; logic [DW-1:0] expData; logic [NR-1:0] expPulse;
  } vec_t;

  int nChecks = 0;
  int nFail   = 0;
  logic [DW-1:0] model [NR];
  wr_exp_t wrQ[$];
  rd_exp_t rdQ[$];
  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] modelVec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  // Bench model of a write: only in-range, read-write slots take data.
  task automatic modelWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr >> 2);
    if (idx < NR && !RO[idx]) begin
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    end
  endtask

  function automatic vec_t mkVec(bit rd, logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] s,
                                 logic [1:0] er, logic [DW-1:0] ed, logic [NR-1:0] ep);
    vec_t v;
    v.isRead = rd; v.addr = a; v.data = d; v.strb = s;
    v.expResp = er; v.expData = ed; v.expPulse = ep;
    return v;
  endfunction

  task automatic acceptWrite();
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    checkOutput("bvalid_drop", bus.bvalid, 1'b0);
    checkOutput("pulse_one_cycle", wrPulse, '0);
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                         input logic [1:0] expResp, input logic [NR-1:0] expPulse, input int hold);
    wr_exp_t e;
    int n;
    @(negedge clk);
    bus.waddr = addr; bus.wavalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    wrQ.push_back('{resp: expResp, pulse: expPulse});
    n = 0;
    while (!(bus.waready && bus.wready) && n < 20) begin @(negedge clk); n++; end
    checkOutput("wr_handshake", bus.waready && bus.wready, 1'b1);
    @(posedge clk); #1;
    bus.wavalid = 1'b0; bus.wvalid = 1'b0;
    modelWrite(addr, data, strb);
    checkOutput("bvalid", bus.bvalid, 1'b1);
    if (bus.bvalid) begin
      e = wrQ.pop_front();
      checkOutput("wresp", bus.wresp, e.resp);
      checkOutput("wr_pulse", wrPulse, e.pulse);
    end
    checkOutput("reg_o", regO, modelVec());
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_bvalid", bus.bvalid, 1'b1);
      checkOutput("hold_wresp", bus.wresp, expResp);
      checkOutput("hold_readies", {bus.waready, bus.wready}, 2'b00);
      checkOutput("hold_pulse", wrPulse, '0);
    end
    acceptWrite();
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input logic [1:0] expResp,
                        input logic [DW-1:0] expData, input int hold);
    rd_exp_t e;
    int n;
    @(negedge clk);
    bus.raddr = addr; bus.arvalid = 1'b1;
    rdQ.push_back('{resp: expResp, data: expData});
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    checkOutput("ar_handshake", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    checkOutput("rvalid", bus.rvalid, 1'b1);
    if (bus.rvalid) begin
      e = rdQ.pop_front();
      checkOutput("rresp", bus.rresp, e.resp);
      checkOutput("rdata", bus.rdata, e.data);
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_rvalid", bus.rvalid, 1'b1);
      checkOutput("hold_rdata", bus.rdata, expData);
      checkOutput("hold_arready", bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    checkOutput("rvalid_drop", bus.rvalid, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isRead) doRead(v.addr, v.expResp, v.expData, 0);
    else          doWrite(v.addr, v.data, v.strb, v.expResp, v.expPulse, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.waddr = '0; bus.wavalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.raddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      model[i] = '0;
      regI[i*DW +: DW] = $urandom;
    end
    regI[2*DW +: DW] = 32'h12345678;

    vecs[0]  = mkVec(0, 8'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY,   32'h0,        16'h0002);
    vecs[1]  = mkVec(1, 8'h04, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF, 16'h0000);
    vecs[2]  = mkVec(0, 8'h08, 32'h11111111, 4'hF, RESP_SLVERR, 32'h0,        16'h0000);
    vecs[3]  = mkVec(1, 8'h08, 32'h0,        4'h0, RESP_OKAY,   32'h12345678, 16'h0000);
    vecs[4]  = mkVec(0, 8'h40, 32'h22222222, 4'hF, RESP_SLVERR, 32'h0,        16'h0000);
    vecs[5]  = mkVec(1, 8'h40, 32'h0,        4'h0, RESP_SLVERR, 32'h0,        16'h0000);
    vecs[6]  = mkVec(0, 8'h3C, 32'hA5A5A5A5, 4'hA, RESP_OKAY,   32'h0,        16'h8000);
    vecs[7]  = mkVec(1, 8'h3F, 32'h0,        4'h0, RESP_OKAY,   32'hA500A500, 16'h0000);
    vecs[8]  = mkVec(0, 8'h00, 32'hFFFFFFFF, 4'h0, RESP_OKAY,   32'h0,        16'h0001);
    vecs[9]  = mkVec(1, 8'h00, 32'h0,        4'h0, RESP_OKAY,   32'h0,        16'h0000);
    vecs[10] = mkVec(0, 8'hFC, 32'h33333333, 4'hF, RESP_SLVERR, 32'h0,        16'h0000);
    vecs[11] = mkVec(1, 8'h0C, 32'h0,        4'h0, RESP_OKAY,   32'h0,        16'h0000);

    repeat (3) @(negedge clk);
    checkOutput("rst_readies", {bus.waready, bus.wready, bus.arready}, 3'b000);
    checkOutput("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    checkOutput("rst_resps", {bus.wresp, bus.rresp}, 4'b0000);
    checkOutput("rst_rdata", bus.rdata, '0);
    checkOutput("rst_reg_o", regO, '0);
    checkOutput("rst_pulse", wrPulse, '0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready_low", bus.waready, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_rst_ready_high", {bus.waready, bus.wready, bus.arready}, 3'b111);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // W leads AW by three cycles with a partial strobe.
    @(negedge clk);
    bus.wdata = 32'h0000AAAA; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
    wrQ.push_back('{resp: RESP_OKAY, pulse: 16'h0002});
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    checkOutput("waitA_readies", {bus.waready, bus.wready}, 2'b10);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("waitA_no_bvalid", bus.bvalid, 1'b0);
    end
    @(negedge clk);
    bus.waddr = 8'h04; bus.wavalid = 1'b1;
    @(posedge clk); #1;
    bus.wavalid = 1'b0;
    modelWrite(8'h04, 32'h0000AAAA, 4'h3);
    checkOutput("split_bvalid", bus.bvalid, 1'b1);
    if (bus.bvalid) begin
      wr_exp_t e;
      e = wrQ.pop_front();
      checkOutput("split_wresp", bus.wresp, e.resp);
      checkOutput("split_pulse", wrPulse, e.pulse);
    end
    checkOutput("split_reg1", regO[1*DW +: DW], 32'hDEADAAAA);
    acceptWrite();

    doWrite(8'h10, 32'h55AA55AA, 4'hF, RESP_OKAY, 16'h0010, 5);
    doRead(8'h10, RESP_OKAY, 32'h55AA55AA, 5);

    // Read and write of register 3 handshake on the same edge.
    @(negedge clk);
    bus.waddr = 8'h0C; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.wavalid = 1'b1; bus.wvalid = 1'b1; bus.raddr = 8'h0C; bus.arvalid = 1'b1;
    wrQ.push_back('{resp: RESP_OKAY, pulse: 16'h0008});
    rdQ.push_back('{resp: RESP_OKAY, data: 32'h0});
    @(posedge clk); #1;
    bus.wavalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    modelWrite(8'h0C, 32'hCAFEF00D, 4'hF);
    checkOutput("same_edge_valids", {bus.bvalid, bus.rvalid}, 2'b11);
    if (bus.rvalid) begin
      rd_exp_t r;
      r = rdQ.pop_front();
      checkOutput("same_edge_rdata", bus.rdata, r.data);
      checkOutput("same_edge_rresp", bus.rresp, r.resp);
    end
    if (bus.bvalid) begin
      wr_exp_t e;
      e = wrQ.pop_front();
      checkOutput("same_edge_pulse", wrPulse, e.pulse);
    end
    checkOutput("same_edge_reg_o", regO, modelVec());
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    checkOutput("same_edge_drop", {bus.bvalid, bus.rvalid}, 2'b00);

    // Reset lands after AW is accepted but before W arrives.
    @(negedge clk);
    bus.waddr = 8'h14; bus.wavalid = 1'b1;
    @(posedge clk); #1;
    bus.wavalid = 1'b0;
    checkOutput("waitW_readies", {bus.waready, bus.wready}, 2'b01);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_readies", {bus.waready, bus.wready, bus.arready}, 3'b000);
    checkOutput("midrst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    checkOutput("midrst_reg_o", regO, '0);
    checkOutput("midrst_pulse", wrPulse, '0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_flag_low", bus.waready, 1'b0);
    @(posedge clk); #1;
    checkOutput("midrst_flag_high", {bus.waready, bus.wready, bus.arready}, 3'b111);
    doWrite(8'h14, 32'h13572468, 4'hF, RESP_OKAY, 16'h0020, 0);
    doRead(8'h14, RESP_OKAY, 32'h13572468, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
